// File: rtl/vericlock_pkg.sv
// Shared types and constants for the vericlock set-button path.
// Holds the pulse-generator state enum, button indices and default timing.
package vericlock_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      HOLD     = 2'd1,
      REPEAT   = 2'd2,
      WAIT_REL = 2'd3
   } state_t;

   typedef logic [1:0] sel_t;

   localparam sel_t BTN_HOUR_DAY  = 2'd0;
   localparam sel_t BTN_MIN_MONTH = 2'd1;
   localparam sel_t BTN_SEC_YEAR  = 2'd2;

   localparam int DEF_HOLD_CYCLES   = 50_000_000;
   localparam int DEF_REPEAT_CYCLES = 10_000_000;

   // Lowest-numbered pressed (low) button wins; caller guarantees one is pressed.
   function automatic sel_t first_low(input logic [2:0] b);
      if (!b[0]) return BTN_HOUR_DAY;
      else if (!b[1]) return BTN_MIN_MONTH;
      else return BTN_SEC_YEAR;
   endfunction

endpackage

// File: rtl/inc_pulse_gen.sv
// Turns held active-low set buttons into one-cycle increment pulses with auto-repeat.
// Pulse appears the cycle after the press edge; all outputs are registered.
module inc_pulse_gen
   import vericlock_pkg::*;
#(
   parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
   parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
   input  logic       clk_100MHz,
   input  logic       reset,
   input  logic       datetime,
   input  logic       inc_enable,
   input  logic [2:0] btn_n,
   output logic       inc_hour,
   output logic       inc_min,
   output logic       inc_sec,
   output logic       inc_day,
   output logic       inc_month,
   output logic       inc_year,
   output logic       busy
);

   localparam int            CW        = $clog2(HOLD_CYCLES);
   localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] REP_LOAD  = CW'(REPEAT_CYCLES - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   sel_t          sel_q, sel_d;
   logic          mode_q, mode_d;
   logic [5:0]    inc_q, inc_d;   // {year, month, day, sec, min, hour}
   logic          busy_q, busy_d;
   logic          pulse;
   logic [3:0]    btn_ext;

   // Padding keeps the btn_n[sel] lookup in range for every sel encoding.
   assign btn_ext = {1'b1, btn_n};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      mode_d  = mode_q;
      pulse   = 1'b0;
      inc_d   = '0;

      case (state_q)
         IDLE: begin
            if (inc_enable && (btn_n != 3'b111)) begin
               state_d = HOLD;
               sel_d   = first_low(btn_n);
               mode_d  = datetime;
               cnt_d   = HOLD_LOAD;
               pulse   = 1'b1;
            end
         end
         HOLD, REPEAT: begin
            if (!inc_enable) begin
               state_d = IDLE;
            end else if (datetime != mode_q) begin
               state_d = WAIT_REL;
            end else if (btn_ext[sel_q]) begin
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               state_d = REPEAT;
               cnt_d   = REP_LOAD;
               pulse   = 1'b1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         WAIT_REL: begin
            if (!inc_enable || (btn_n == 3'b111)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (pulse) begin
         case (sel_d)
            BTN_HOUR_DAY:  inc_d = mode_d ? 6'b000001 : 6'b001000;
            BTN_MIN_MONTH: inc_d = mode_d ? 6'b000010 : 6'b010000;
            BTN_SEC_YEAR:  inc_d = mode_d ? 6'b000100 : 6'b100000;
            default:       inc_d = '0;
         endcase
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sel_q   <= BTN_HOUR_DAY;
         mode_q  <= 1'b0;
         inc_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         mode_q  <= mode_d;
         inc_q   <= inc_d;
         busy_q  <= busy_d;
      end
   end

   assign inc_hour  = inc_q[0];
   assign inc_min   = inc_q[1];
   assign inc_sec   = inc_q[2];
   assign inc_day   = inc_q[3];
   assign inc_month = inc_q[4];
   assign inc_year  = inc_q[5];
   assign busy      = busy_q;

endmodule

// File: tb/tb_inc_pulse_gen.sv
// Bench for inc_pulse_gen: vector table, hand-written corner sequences and random
// stimulus against a timing-arithmetic reference model.
module tb_inc_pulse_gen;

   localparam int H = 10;
   localparam int R = 4;

   logic       clk_100MHz;
   logic       reset;
   logic       datetime;
   logic       inc_enable;
   logic [2:0] btn_n;
   logic       inc_hour, inc_min, inc_sec, inc_day, inc_month, inc_year, busy;

   int checks = 0;
   int errors = 0;

   // Reference model: pulse times come from elapsed edges since the press.
   int         e_cnt = 0;
   int         m_t0;
   int         m_sel;
   logic       m_mode;
   logic       m_active = 1'b0;
   logic       m_wait   = 1'b0;
   logic [5:0] m_inc    = '0;
   logic       m_busy   = 1'b0;

   typedef struct {
      logic       dt;
      logic       en;
      logic [2:0] btn;
      logic [6:0] exp;   // {busy, year, month, day, sec, min, hour}
   } vec_t;

   vec_t tbl[9];

   inc_pulse_gen #(.HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut (
      .clk_100MHz(clk_100MHz),
      .reset     (reset),
      .datetime  (datetime),
      .inc_enable(inc_enable),
      .btn_n     (btn_n),
      .inc_hour  (inc_hour),
      .inc_min   (inc_min),
      .inc_sec   (inc_sec),
      .inc_day   (inc_day),
      .inc_month (inc_month),
      .inc_year  (inc_year),
      .busy      (busy)
   );

   initial clk_100MHz = 1'b0;
   always #5 clk_100MHz = ~clk_100MHz;

   function automatic logic [6:0] outs();
      return {busy, inc_year, inc_month, inc_day, inc_sec, inc_min, inc_hour};
   endfunction

   task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic fire();
      m_inc[m_mode ? m_sel : m_sel + 3] = 1'b1;
   endtask

   task automatic model_clear();
      m_active = 1'b0;
      m_wait   = 1'b0;
      m_inc    = '0;
      m_busy   = 1'b0;
   endtask

   task automatic model_step();
      int k;
      m_inc = '0;
      e_cnt++;
      if (reset) begin
         model_clear();
      end else if (!m_active && !m_wait) begin
         if (inc_enable && btn_n != 3'b111) begin
            m_active = 1'b1;
            m_mode   = datetime;
            m_sel    = !btn_n[0] ? 0 : (!btn_n[1] ? 1 : 2);
            m_t0     = e_cnt;
            fire();
         end
      end else if (m_active) begin
         if (!inc_enable) m_active = 1'b0;
         else if (datetime != m_mode) begin
            m_active = 1'b0;
            m_wait   = 1'b1;
         end else if (btn_n[m_sel]) m_active = 1'b0;
         else begin
            k = e_cnt - m_t0;
            if (k >= H && (k - H) % R == 0) fire();
         end
      end else if (!inc_enable || btn_n == 3'b111) begin
         m_wait = 1'b0;
      end
      m_busy = m_active || m_wait;
   endtask

   // One clock: model samples the same inputs the DUT samples, outputs checked 1 ns later.
   task automatic cycle();
      @(posedge clk_100MHz);
      model_step();
      #1;
      check("model", outs(), {m_busy, m_inc});
   endtask

   task automatic idle_cycles(input int n);
      btn_n = 3'b111;
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      int cnt, other, bad;
      logic busy_ok;

      tbl[0] = '{1'b1, 1'b1, 3'b111, 7'b0000000};
      tbl[1] = '{1'b1, 1'b1, 3'b110, 7'b1000001};
      tbl[2] = '{1'b1, 1'b1, 3'b110, 7'b1000000};
      tbl[3] = '{1'b1, 1'b1, 3'b110, 7'b1000000};
      tbl[4] = '{1'b1, 1'b1, 3'b111, 7'b0000000};
      tbl[5] = '{1'b1, 1'b1, 3'b111, 7'b0000000};
      tbl[6] = '{1'b1, 1'b0, 3'b000, 7'b0000000};
      tbl[7] = '{1'b0, 1'b0, 3'b010, 7'b0000000};
      tbl[8] = '{1'b0, 1'b1, 3'b111, 7'b0000000};

      reset      = 1'b1;
      datetime   = 1'b1;
      inc_enable = 1'b1;
      btn_n      = 3'b111;
      #3;
      check("reset_state", outs(), 7'b0);
      cycle();
      cycle();
      reset = 1'b0;
      idle_cycles(2);

      // Short tap and disable vectors
      for (int i = 0; i < 9; i++) begin
         datetime   = tbl[i].dt;
         inc_enable = tbl[i].en;
         btn_n      = tbl[i].btn;
         cycle();
         check($sformatf("table[%0d]", i), outs(), tbl[i].exp);
      end

      // Hold 30 cycles in date mode on min/month
      datetime = 1'b0;
      inc_enable = 1'b1;
      cnt = 0;
      bad = 0;
      for (int i = 1; i <= 30; i++) begin
         btn_n = 3'b101;
         cycle();
         if (inc_month) begin
            cnt++;
            if (!(i == 1 || i == 11 || i == 15 || i == 19 || i == 23 || i == 27)) bad++;
         end
      end
      check_int("hold30_pulses", cnt, 6);
      check_int("hold30_misplaced", bad, 0);
      cnt = 0;
      btn_n = 3'b111;
      for (int i = 0; i < 6; i++) begin
         cycle();
         if (inc_month) cnt++;
      end
      check_int("hold30_after_release", cnt, 0);

      // Simultaneous press: only day, then release bit 0 -> IDLE -> month
      cnt = 0;
      other = 0;
      for (int i = 1; i <= 12; i++) begin
         btn_n = 3'b000;
         cycle();
         if (inc_day) cnt++;
         if (inc_month || inc_year || inc_hour || inc_min || inc_sec) other++;
      end
      check_int("simul_day_pulses", cnt, 2);
      check_int("simul_other_pulses", other, 0);
      btn_n = 3'b001;
      cycle();
      check("simul_release_idle", outs(), 7'b0000000);
      cycle();
      check("simul_new_month", outs(), 7'b1010000);
      idle_cycles(3);

      // Mode flip mid-hold on sec
      datetime = 1'b1;
      cnt = 0;
      busy_ok = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         btn_n = 3'b011;
         if (i == 5) datetime = 1'b0;
         cycle();
         if (i >= 5 && (inc_sec || inc_year)) cnt++;
         if (!busy) busy_ok = 1'b0;
      end
      check_int("flip_no_pulses", cnt, 0);
      check_int("flip_busy_held", int'(busy_ok), 1);
      btn_n = 3'b111;
      cycle();
      check("flip_release", outs(), 7'b0);

      // Reset in the middle of a hold, button kept pressed
      datetime = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         btn_n = 3'b110;
         cycle();
      end
      check_int("pre_reset_busy", int'(busy), 1);
      reset = 1'b1;
      #1;
      model_clear();
      check("reset_async", outs(), 7'b0);
      cycle();
      cycle();
      reset = 1'b0;
      cycle();
      check("reset_repress", outs(), 7'b1000001);
      idle_cycles(2);

      // Release coinciding with counter reaching zero
      for (int i = 1; i <= 10; i++) begin
         btn_n = 3'b110;
         cycle();
      end
      btn_n = 3'b111;
      cycle();
      check("release_at_zero", outs(), 7'b0);
      idle_cycles(2);

      // Random stimulus against the model
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            case ($urandom_range(0, 5))
               0, 1: btn_n = 3'b111;
               2:    btn_n = 3'b110;
               3:    btn_n = 3'b101;
               4:    btn_n = 3'b011;
               default: btn_n = 3'($urandom_range(0, 7));
            endcase
         end
         if ($urandom_range(0, 39) == 0) datetime = ~datetime;
         if ($urandom_range(0, 24) == 0) inc_enable = ~inc_enable;
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/inc_pulse_gen.md
# inc_pulse_gen

- Turns the debounced, active-low set buttons (`inc_0`..`inc_2`) into single-cycle increment pulses for the clock and calendar modules.
- Has press-and-hold auto-repeat: one pulse on press, a second after a hold delay, then one every repeat interval.
- Sits between the debounce stage and the `clock`/`calendar` instances in `vericlock`.
- Replaces the level-based `inc_*` combinational assignments, so one press gives exactly one increment.

## Interface
Parameters:
- `HOLD_CYCLES`, 50_000_000 — cycles from first pulse to first repeat pulse (500 ms at 100 MHz); legal ≥ 2
- `REPEAT_CYCLES`, 10_000_000 — cycles between repeat pulses (100 ms); legal ≥ 2, ≤ `HOLD_CYCLES`

Ports:
- `clk_100MHz`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `datetime`  in  1  debounced mode: 1 = time (hour/min/sec), 0 = date (day/month/year)
- `inc_enable`  in  1  debounced set-mode enable; 0 suppresses all pulses
- `btn_n`  in  3  debounced buttons, active-low; bit 0 = hour/day, bit 1 = min/month, bit 2 = sec/year
- `inc_hour`, `inc_min`, `inc_sec`  out  1 each  one-cycle increment pulses (time mode)
- `inc_day`, `inc_month`, `inc_year`  out  1 each  one-cycle increment pulses (date mode)
- `busy`  out  1  high while any button is being serviced (state ≠ IDLE)

## Operation
- All outputs are registered. Reset drives every output to 0, the state to IDLE and all counters to 0.
- States:
  - **IDLE**: waits for a press.
  - **HOLD**: counts the hold delay.
  - **REPEAT**: issues repeat pulses.
  - **WAIT_REL**: waits until all buttons are released.
- IDLE → HOLD when `inc_enable`=1 and any `btn_n` bit is 0.
  - Latch the selected index `sel`: the lowest-numbered pressed bit wins.
  - Latch `mode` = `datetime`.
  - Issue the first pulse.
  - Load the counter with `HOLD_CYCLES`-1.
- HOLD: decrement each cycle. At 0, issue a pulse, load `REPEAT_CYCLES`-1 and go to REPEAT.
- REPEAT: decrement each cycle. At 0, issue a pulse and reload `REPEAT_CYCLES`-1.
- In HOLD or REPEAT, the next state is evaluated with this priority (highest first):
  1. `inc_enable`=0 → IDLE, no pulse that cycle.
  2. `datetime` ≠ latched `mode` → WAIT_REL, no pulse.
  3. `btn_n[sel]`=1 (released) → IDLE, no pulse.
  4. Otherwise continue counting.
- Other buttons pressed while servicing `sel` are ignored. They produce no pulses.
- WAIT_REL → IDLE when `btn_n` = 3'b111 or `inc_enable`=0.
- Pulse routing uses the latched `mode` and `sel`: mode=1 maps sel 0/1/2 to hour/min/sec; mode=0 maps them to day/month/year.
- At most one `inc_*` output is high in any cycle.
- The counter width is $clog2(`HOLD_CYCLES`). It never wraps below 0.

## Timing
- Press first sampled low at rising edge N (in IDLE, enabled) → pulse high during cycle N+1, for exactly one cycle.
- Held continuously:
  - second pulse at N+1+`HOLD_CYCLES`;
  - subsequent pulses every `REPEAT_CYCLES` cycles after that.
- Release sampled at edge M → state is IDLE in cycle M+1. A new press can be sampled at edge M+1, giving a pulse at M+2.
- A release that coincides with the counter reaching 0 wins: no pulse.
- `busy` rises in cycle N+1 and falls in the cycle the state returns to IDLE.
- Asserting `reset` mid-hold clears all outputs immediately (asynchronously). After deassertion, a still-held button is treated as a new press.

## Structure
- Shared package `vericlock_pkg`:
  - state enum (`IDLE`, `HOLD`, `REPEAT`, `WAIT_REL`);
  - button index constants `BTN_HOUR_DAY`=0, `BTN_MIN_MONTH`=1, `BTN_SEC_YEAR`=2;
  - default `HOLD_CYCLES` and `REPEAT_CYCLES` values.
- Single module. The priority encoder, down-counter and output decode are inline. No sub-module is needed.

## Test plan
All scenarios use `HOLD_CYCLES`=10, `REPEAT_CYCLES`=4.
- **Short tap:** `datetime`=1, `inc_enable`=1; `btn_n`=3'b110 for 3 cycles → exactly one `inc_hour` pulse, one cycle after the press edge; `busy` for 3 cycles; all other outputs stay 0.
- **Hold 30 cycles:** `datetime`=0, `btn_n[1]` low → `inc_month` pulses at press+1, +11, +15, +19, +23, +27; 6 pulses total; none after release.
- **Simultaneous press:** `btn_n`=3'b000 in date mode → only `inc_day` pulses; after bit 0 is released while bits 1 and 2 are still low, IDLE is reached, then a new press gives an `inc_month` pulse.
- **Mode flip mid-hold:** holding `btn_n[2]`, toggle `datetime` at cycle 5 → no further pulses; `busy` stays 1 until `btn_n`=3'b111, then 0.
- **Disable and reset:**
  - `inc_enable`=0 with buttons pressed → no pulses and `busy`=0.
  - `reset` asserted at cycle 7 of a hold → all outputs 0 the same cycle.
  - After `reset` is released with the button still held → pulse 1 cycle after the first sampled edge.
- **Release coinciding with counter 0:** release exactly at press+10 → no pulse at press+11.
